// File: rtl/watch_button_ctrl.sv
// Front-end for the watch buttons: synchronizes and debounces three raw keys,
// then turns them into mode pulses and auto-repeating up/down pulses.
module watch_button_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_RATE     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_mode_raw,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic mode_button,
   output logic up,
   output logic down
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [DW-1:0] DB_LIMIT   = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_ONE     = DW'(1);
   localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE);
   localparam logic [RW-1:0] R_ONE      = RW'(1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

   // Key slots: bit 0 mode, bit 1 up, bit 2 down.
   logic [2:0]    raw, sync1, sync2, stable;
   logic [DW-1:0] db_cnt [3];
   logic          mode_prev;
   logic          mode_pulse;
   logic          conflict;

   // Repeat engines: index 0 up, index 1 down.
   rpt_state_t    state      [2];
   rpt_state_t    next_state [2];
   logic [RW-1:0] rpt_cnt    [2];
   logic [RW-1:0] next_cnt   [2];
   logic [1:0]    lock;
   logic [1:0]    rpt_pulse;

   assign raw = {btn_down_raw, btn_up_raw, btn_mode_raw};

   // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // A level is accepted once it has differed from stable for more than DEBOUNCE_CYCLES samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable    <= '0;
         mode_prev <= 1'b0;
         for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
      end else begin
         mode_prev <= stable[0];
         for (int k = 0; k < 3; k++) begin
            if (sync2[k] == stable[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LIMIT) begin
               stable[k] <= sync2[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + DB_ONE;
            end
         end
      end
   end

   assign mode_pulse = stable[0] & ~mode_prev;
   assign conflict   = stable[1] & stable[2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock <= '0;
         for (int i = 0; i < 2; i++) begin
            state[i]   <= IDLE;
            rpt_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            state[i]   <= next_state[i];
            rpt_cnt[i] <= next_cnt[i];
            if (!stable[i+1])  lock[i] <= 1'b0;
            else if (conflict) lock[i] <= 1'b1;
         end
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_state = state;
      next_cnt   = rpt_cnt;
      for (int i = 0; i < 2; i++) begin
         if (!stable[i+1] || conflict) begin
            next_state[i] = IDLE;
            next_cnt[i]   = '0;
         end else begin
            case (state[i])
               IDLE: begin
                  if (!lock[i]) begin
                     next_state[i] = DELAY;
                     next_cnt[i]   = DELAY_LOAD;
                  end
               end
               DELAY, REPEAT: begin
                  if (rpt_cnt[i] == R_ONE) begin
                     next_state[i] = REPEAT;
                     next_cnt[i]   = RATE_LOAD;
                  end else begin
                     next_cnt[i] = rpt_cnt[i] - R_ONE;
                  end
               end
               default: begin
                  next_state[i] = IDLE;
                  next_cnt[i]   = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      rpt_pulse = '0;
      for (int i = 0; i < 2; i++) begin
         if (stable[i+1] && !conflict) begin
            if (state[i] == IDLE) rpt_pulse[i] = ~lock[i];
            else                  rpt_pulse[i] = (rpt_cnt[i] == R_ONE);
         end
      end
   end

   // Mode wins a coincident pulse; the dropped up/down pulse leaves FSM timing untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_button <= 1'b0;
         up          <= 1'b0;
         down        <= 1'b0;
      end else begin
         mode_button <= mode_pulse;
         up          <= rpt_pulse[0] & ~mode_pulse;
         down        <= rpt_pulse[1] & ~mode_pulse;
      end
   end

endmodule
